// File: rtl/stack_guarded_pkg.sv
// Shared definitions for the guarded hardware stack: operation encoding,
// overflow-mode encodings and the operation decoder.
package stack_guarded_pkg;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_PUSH    = 2'd1;
    localparam logic [1:0] OP_POP     = 2'd2;
    localparam logic [1:0] OP_REPLACE = 2'd3;

    localparam int OVF_REJECT = 0;
    localparam int OVF_WRAP   = 1;

    // Pop has priority over update when change and dec are both set.
    function automatic logic [1:0] decode_op(input logic change,
                                             input logic dec,
                                             input logic update);
        logic [1:0] op;
        op = OP_NOP;
        if (change && dec) begin
            op = OP_POP;
        end else if (change && update) begin
            op = OP_PUSH;
        end else if (!change && update) begin
            op = OP_REPLACE;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Entry storage beneath the top-of-stack register: one synchronous write
// port, one asynchronous read port, contents are not reset.
module stack_ram #(
    parameter int WIDTH       = 16,
    parameter int SADDR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [SADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [SADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]       rdata
);

    logic [WIDTH-1:0] mem [2**SADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_guarded.sv
// LIFO stack with a dedicated top-of-stack register, circular storage below
// it, and sticky overflow/underflow flags; overflow either rejects or wraps.
module stack_guarded
    import stack_guarded_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SADDR_WIDTH = 8,
    parameter int OVF_MODE    = OVF_REJECT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wait_state,
    input  logic [WIDTH-1:0]       D,
    input  logic                   change,
    input  logic                   dec,
    input  logic                   update,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       Q,
    output logic [SADDR_WIDTH:0]   count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [SADDR_WIDTH:0] DEPTH = {1'b1, {SADDR_WIDTH{1'b0}}};
    localparam logic [SADDR_WIDTH:0] ONE   = {{SADDR_WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0]       top_q;
    logic [SADDR_WIDTH:0]   cnt;
    logic [SADDR_WIDTH-1:0] wr_ptr;
    logic [SADDR_WIDTH-1:0] rd_ptr;
    logic [WIDTH-1:0]       below_top;
    logic                   ovf_flag;
    logic                   unf_flag;

    logic [1:0] op;
    logic       is_empty;
    logic       is_full;
    logic       do_push;
    logic       do_pop;
    logic       do_replace;
    logic       ram_we;
    logic       ovf_event;
    logic       unf_event;

    always_comb begin
        op         = wait_state ? OP_NOP : decode_op(change, dec, update);
        is_empty   = (cnt == '0);
        is_full    = (cnt == DEPTH);
        // In wrap mode a push while full overwrites the oldest slot, which
        // is exactly the next write position of the circular storage.
        do_push    = (op == OP_PUSH) && (!is_full || (OVF_MODE == OVF_WRAP));
        do_pop     = (op == OP_POP) && !is_empty;
        do_replace = (op == OP_REPLACE) && !is_empty;
        ram_we     = do_push && !is_empty;
        ovf_event  = (op == OP_PUSH) && is_full;
        unf_event  = ((op == OP_POP) || (op == OP_REPLACE)) && is_empty;
    end

    // Storage holds everything below the top; the entry just under the top
    // sits one slot behind the write pointer.
    assign rd_ptr = wr_ptr - 1'b1;

    stack_ram #(
        .WIDTH      (WIDTH),
        .SADDR_WIDTH(SADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(wr_ptr),
        .wdata(top_q),
        .raddr(rd_ptr),
        .rdata(below_top)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top_q  <= '0;
            cnt    <= '0;
            wr_ptr <= '0;
        end else if (do_push) begin
            top_q <= D;
            if (!is_empty) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (!is_full) begin
                cnt <= cnt + ONE;
            end
        end else if (do_pop) begin
            cnt <= cnt - ONE;
            if (cnt == ONE) begin
                top_q <= '0;
            end else begin
                top_q  <= below_top;
                wr_ptr <= rd_ptr;
            end
        end else if (do_replace) begin
            top_q <= D;
        end
    end

    // A new error in the same cycle as clr_err keeps its flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_flag <= 1'b0;
            unf_flag <= 1'b0;
        end else begin
            ovf_flag <= (ovf_flag && !clr_err) || ovf_event;
            unf_flag <= (unf_flag && !clr_err) || unf_event;
        end
    end

    assign Q         = top_q;
    assign count     = cnt;
    assign empty     = (cnt == '0);
    assign full      = (cnt == DEPTH);
    assign overflow  = ovf_flag;
    assign underflow = unf_flag;

endmodule

// File: tb/tb_stack_guarded.sv
// Directed bench for stack_guarded: one reject-mode and one wrap-mode
// instance driven by the same stimulus, each checked against hand values.
module tb_stack_guarded;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wait_state = 1'b0;
    logic [15:0] D = '0;
    logic        change = 1'b0;
    logic        dec = 1'b0;
    logic        update = 1'b0;
    logic        clr_err = 1'b0;

    logic [15:0] q_rej, q_wrp;
    logic [2:0]  count_rej, count_wrp;
    logic        empty_rej, empty_wrp, full_rej, full_wrp;
    logic        ovf_rej, ovf_wrp, unf_rej, unf_wrp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stack_guarded #(.WIDTH(16), .SADDR_WIDTH(2), .OVF_MODE(0)) dut_rej (
        .clk(clk), .reset(reset), .wait_state(wait_state), .D(D),
        .change(change), .dec(dec), .update(update), .clr_err(clr_err),
        .Q(q_rej), .count(count_rej), .empty(empty_rej), .full(full_rej),
        .overflow(ovf_rej), .underflow(unf_rej)
    );

    stack_guarded #(.WIDTH(16), .SADDR_WIDTH(2), .OVF_MODE(1)) dut_wrp (
        .clk(clk), .reset(reset), .wait_state(wait_state), .D(D),
        .change(change), .dec(dec), .update(update), .clr_err(clr_err),
        .Q(q_wrp), .count(count_wrp), .empty(empty_wrp), .full(full_wrp),
        .overflow(ovf_wrp), .underflow(unf_wrp)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one operation for exactly one rising edge, then return to idle
    // 1 time unit after that edge so outputs can be sampled.
    task automatic do_op(input logic c, input logic d_dec, input logic u,
                         input logic [15:0] data, input logic ws,
                         input logic clr);
        change     = c;
        dec        = d_dec;
        update     = u;
        D          = data;
        wait_state = ws;
        clr_err    = clr;
        @(posedge clk);
        #1;
        change     = 1'b0;
        dec        = 1'b0;
        update     = 1'b0;
        D          = '0;
        wait_state = 1'b0;
        clr_err    = 1'b0;
    endtask

    task automatic push(input logic [15:0] data);
        do_op(1'b1, 1'b0, 1'b1, data, 1'b0, 1'b0);
    endtask

    task automatic pop();
        do_op(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    logic [15:0] exp_rej [4];
    logic [15:0] exp_wrp [4];

    initial begin
        exp_rej[0] = 16'h3333; exp_rej[1] = 16'h2222;
        exp_rej[2] = 16'h1111; exp_rej[3] = 16'h0000;
        exp_wrp[0] = 16'h4444; exp_wrp[1] = 16'h3333;
        exp_wrp[2] = 16'h2222; exp_wrp[3] = 16'h0000;

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_q",     q_rej, 0);
        check("rst_count", count_rej, 0);
        check("rst_empty", empty_rej, 1);
        check("rst_full",  full_rej, 0);
        check("rst_ovf",   ovf_rej, 0);
        check("rst_unf",   unf_rej, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill to capacity and drain
        push(16'h1111);
        check("push1_q", q_rej, 16'h1111);
        check("push1_count", count_rej, 1);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        check("fill_q", q_rej, 16'h4444);
        check("fill_count", count_rej, 4);
        check("fill_full", full_rej, 1);
        for (int i = 0; i < 4; i++) begin
            pop();
            check($sformatf("drain_q%0d", i), q_rej, exp_rej[i]);
            check($sformatf("drain_count%0d", i), count_rej, 3 - i);
        end
        check("drain_empty", empty_rej, 1);
        check("drain_full", full_rej, 0);

        // Overflow: reject keeps the old top, wrap discards the oldest
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        check("pre_ovf_flag", ovf_rej, 0);
        push(16'h5555);
        check("rej_ovf_q", q_rej, 16'h4444);
        check("rej_ovf_count", count_rej, 4);
        check("rej_ovf_flag", ovf_rej, 1);
        check("wrp_ovf_q", q_wrp, 16'h5555);
        check("wrp_ovf_count", count_wrp, 4);
        check("wrp_ovf_flag", ovf_wrp, 1);
        do_op(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        check("rej_ovf_clr", ovf_rej, 0);
        check("wrp_ovf_clr", ovf_wrp, 0);
        check("rej_clr_keep_q", q_rej, 16'h4444);
        for (int i = 0; i < 4; i++) begin
            pop();
            check($sformatf("rej_pop_q%0d", i), q_rej, exp_rej[i]);
            check($sformatf("wrp_pop_q%0d", i), q_wrp, exp_wrp[i]);
        end
        check("wrp_pop_empty", empty_wrp, 1);
        check("wrp_pop_count", count_wrp, 0);

        // Underflow on empty pop, error wins over same-cycle clear
        pop();
        check("unf_flag", unf_rej, 1);
        check("unf_count", count_rej, 0);
        check("unf_q", q_rej, 0);
        do_op(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        check("unf_clr_collide", unf_rej, 1);
        check("unf_clr_collide_w", unf_wrp, 1);
        // clr_err is honoured even while wait_state is held
        do_op(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check("unf_clr_in_wait", unf_rej, 0);

        // Replace frozen by wait_state, then applied
        push(16'h00AA);
        do_op(1'b0, 1'b0, 1'b1, 16'h00BB, 1'b1, 1'b0);
        check("wait_repl_q", q_rej, 16'h00AA);
        check("wait_repl_q_w", q_wrp, 16'h00AA);
        do_op(1'b1, 1'b0, 1'b1, 16'h0CCC, 1'b1, 1'b0);
        check("wait_push_count", count_rej, 1);
        do_op(1'b0, 1'b0, 1'b1, 16'h00BB, 1'b0, 1'b0);
        check("repl_q", q_rej, 16'h00BB);
        check("repl_count", count_rej, 1);
        check("repl_q_w", q_wrp, 16'h00BB);
        // Push after replace: the replaced value must sit below the new top
        push(16'h0DDD);
        pop();
        check("repl_below_q", q_rej, 16'h00BB);
        pop();
        do_op(1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        check("repl_empty_unf", unf_rej, 1);
        check("repl_empty_q", q_rej, 0);
        check("repl_empty_count", count_rej, 0);

        // Asynchronous reset in mid-cycle with three entries
        push(16'h0101);
        push(16'h0202);
        push(16'h0303);
        check("pre_rst_count", count_rej, 3);
        #2 reset = 1'b1;
        #1;
        check("async_rst_count", count_rej, 0);
        check("async_rst_q", q_rej, 0);
        check("async_rst_empty", empty_rej, 1);
        check("async_rst_unf", unf_rej, 0);
        check("async_rst_count_w", count_wrp, 0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        push(16'h0777);
        check("post_rst_q", q_rej, 16'h0777);
        check("post_rst_count", count_rej, 1);
        pop();
        check("post_rst_pop_q", q_rej, 0);
        check("post_rst_pop_unf", unf_rej, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
